// File: rtl/cnt_pkg.sv
// Shared constants and state encoding for the up/down step-counter decoder.
package cnt_pkg;

    // Value the observed step counter starts from after its own reset.
    localparam int RESET_VAL    = -50;

    // Regular and boosted step sizes in each direction.
    localparam int UP_STEP      = 5;
    localparam int UP_BOOST     = 10;
    localparam int DOWN_STEP    = -9;
    localparam int DOWN_BOOST   = -18;

    // Sample values from which the counter takes its boosted step.
    localparam int UP_TRIGGER   = -16;
    localparam int DOWN_TRIGGER = -2;

    // Beyond these values the counter saturates and repeats its sample.
    localparam int UP_LIMIT     = 230;
    localparam int DOWN_LIMIT   = -221;

    // EMPTY: no prior sample, PRIMED: one sample held, LOCKED: mode decoded,
    // FAULT: last step was illegal.
    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        PRIMED = 2'd1,
        LOCKED = 2'd2,
        FAULT  = 2'd3
    } state_t;

endpackage

// File: rtl/cnt_step_classify.sv
// Combinational classifier: decides whether a delta from a given previous
// sample is a legal up step, a legal down step, a legal saturated hold,
// or illegal. Exactly one of the four flags is high.
module cnt_step_classify
    import cnt_pkg::*;
#(
    parameter int W = 10
) (
    input  logic signed [W-1:0] prev,
    input  logic signed [W:0]   delta,
    output logic                up,
    output logic                down,
    output logic                hold,
    output logic                illegal
);

    // Widen both operands to int so all comparisons against the signed
    // package constants are done as plain signed integer compares.
    int prev_val;
    int delta_val;

    assign prev_val  = int'(prev);
    assign delta_val = int'(delta);

    // Boosted steps are only allowed from the trigger value, and the regular
    // step is forbidden there, so the trigger value admits exactly one size.
    assign up = ((delta_val == UP_STEP) && (prev_val != UP_TRIGGER) && (prev_val <= UP_LIMIT))
             || ((delta_val == UP_BOOST) && (prev_val == UP_TRIGGER));

    assign down = ((delta_val == DOWN_STEP) && (prev_val != DOWN_TRIGGER) && (prev_val >= DOWN_LIMIT))
               || ((delta_val == DOWN_BOOST) && (prev_val == DOWN_TRIGGER));

    // A repeated sample is only legal once the counter is past a limit.
    assign hold = (delta_val == 0) && ((prev_val > UP_LIMIT) || (prev_val < DOWN_LIMIT));

    assign illegal = ~(up | down | hold);

endmodule

// File: rtl/cnt_decoder.sv
// Decodes the direction of an up/down step counter from its sampled output,
// flags illegal steps and keeps a saturating count of them. All outputs are
// registered and reflect an accepted sample one clock after it is taken.
module cnt_decoder
    import cnt_pkg::*;
#(
    parameter int W     = 10,
    parameter int ERR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic signed [W-1:0] cnt_in,
    output logic                mode_out,
    output logic                mode_valid,
    output logic                hold,
    output logic                err,
    output logic signed [W:0]   step,
    output logic [ERR_W-1:0]    err_cnt
);

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    state_t              state;
    state_t              state_nxt;
    logic signed [W-1:0] prev;
    logic signed [W-1:0] prev_nxt;
    logic                mode_known;
    logic                mode_known_nxt;
    logic                mode_nxt;
    logic                hold_nxt;
    logic                err_nxt;
    logic signed [W:0]   step_nxt;
    logic [ERR_W-1:0]    err_cnt_nxt;

    logic signed [W:0]   delta;
    logic                is_up;
    logic                is_down;
    logic                is_hold;
    logic                is_illegal;

    // One extra bit of width makes the difference exact for any pair of samples.
    assign delta = (W+1)'(cnt_in) - (W+1)'(prev);

    cnt_step_classify #(
        .W (W)
    ) u_classify (
        .prev    (prev),
        .delta   (delta),
        .up      (is_up),
        .down    (is_down),
        .hold    (is_hold),
        .illegal (is_illegal)
    );

    // State register.
    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-output decode for one accepted sample.
    // NOTE: every signal gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt      = state;
        prev_nxt       = prev;
        mode_known_nxt = mode_known;
        mode_nxt       = mode_out;
        hold_nxt       = hold;
        err_nxt        = 1'b0;
        step_nxt       = step;
        err_cnt_nxt    = err_cnt;

        if (valid_in) begin
            prev_nxt = cnt_in;
            if (state == EMPTY) begin
                // First sample after reset only seeds prev.
                state_nxt = PRIMED;
            end else begin
                step_nxt = delta;
                hold_nxt = 1'b0;
                if (is_up || is_down) begin
                    state_nxt      = LOCKED;
                    mode_nxt       = is_up;
                    mode_known_nxt = 1'b1;
                end else if (is_hold) begin
                    hold_nxt = 1'b1;
                    // A saturated hold carries no direction information, so a
                    // fault only recovers to LOCKED if a direction was seen.
                    if (state == FAULT) begin
                        state_nxt = mode_known ? LOCKED : PRIMED;
                    end
                end else begin
                    state_nxt = FAULT;
                    err_nxt   = 1'b1;
                    if (err_cnt != ERR_MAX) begin
                        err_cnt_nxt = err_cnt + ERR_W'(1);
                    end
                end
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev       <= '0;
            mode_known <= 1'b0;
            mode_out   <= 1'b0;
            mode_valid <= 1'b0;
            hold       <= 1'b0;
            err        <= 1'b0;
            step       <= '0;
            err_cnt    <= '0;
        end else begin
            prev       <= prev_nxt;
            mode_known <= mode_known_nxt;
            mode_out   <= mode_nxt;
            mode_valid <= (state_nxt == LOCKED);
            hold       <= hold_nxt;
            err        <= err_nxt;
            step       <= step_nxt;
            err_cnt    <= err_cnt_nxt;
        end
    end

    // Mode is declared valid only while the decoder sits in LOCKED.
    always_comb begin
        if (rst == 1'b0 && (mode_valid != (state == LOCKED))) begin
            assert (0) else $error("mode_valid out of step with state");
        end
    end

endmodule

// File: tb/tb_cnt_decoder.sv
// Directed testbench for cnt_decoder with hand-computed expected outputs.
module tb_cnt_decoder;
    import cnt_pkg::*;

    localparam int W     = 10;
    localparam int ERR_W = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                valid_in = 1'b0;
    logic signed [W-1:0] cnt_in = '0;
    logic                mode_out;
    logic                mode_valid;
    logic                hold;
    logic                err;
    logic signed [W:0]   step;
    logic [ERR_W-1:0]    err_cnt;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic              mode_out;
        logic              mode_valid;
        logic              hold;
        logic              err;
        logic signed [W:0] step;
        logic [ERR_W-1:0]  err_cnt;
    } obs_t;

    cnt_decoder #(
        .W     (W),
        .ERR_W (ERR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .cnt_in     (cnt_in),
        .mode_out   (mode_out),
        .mode_valid (mode_valid),
        .hold       (hold),
        .err        (err),
        .step       (step),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input logic m, input logic mv, input logic h,
                                input logic e, input int s, input int c);
        obs_t o;
        o.mode_out   = m;
        o.mode_valid = mv;
        o.hold       = h;
        o.err        = e;
        o.step       = (W+1)'(s);
        o.err_cnt    = ERR_W'(c);
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o = {mode_out, mode_valid, hold, err, step, err_cnt};
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("mode=%0d mv=%0d hold=%0d err=%0d step=%0d err_cnt=%0d",
                         o.mode_out, o.mode_valid, o.hold, o.err, $signed(o.step), o.err_cnt);
    endfunction

    // Present one sample for one clock edge; outputs are then settled.
    task automatic send(input int v);
        @(negedge clk);
        valid_in = 1'b1;
        cnt_in   = W'(v);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        valid_in = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        valid_in = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e;
        @(negedge clk);
        rst = 1'b1;
        #1;
        e = mk(0, 0, 0, 0, 0, 0);
        vectors++;
        if (observe() !== e) begin
            miscompares++;
            $display("FAIL reset_outputs: got %s, expected %s", fmt(observe()), fmt(e));
        end
        vectors++;
        if (dut.state !== EMPTY) begin
            miscompares++;
            $display("FAIL reset_state: got %0d, expected %0d", dut.state, EMPTY);
        end
        do_reset();
    endtask

    task automatic test_up_basic();
        int   s [3] = '{RESET_VAL, -45, -40};
        obs_t e [3];
        e[0] = mk(0, 0, 0, 0, 0, 0);
        e[1] = mk(1, 1, 0, 0, 5, 0);
        e[2] = mk(1, 1, 0, 0, 5, 0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(s[i]);
            vectors++;
            if (observe() !== e[i]) begin
                miscompares++;
                $display("FAIL up_basic[%0d]: got %s, expected %s", i, fmt(observe()), fmt(e[i]));
            end
        end
    endtask

    task automatic test_boost_up();
        int   s [3] = '{-20, -16, -6};
        int   t [2] = '{-16, -11};
        obs_t e [3];
        obs_t f [2];
        e[0] = mk(0, 0, 0, 0, 0, 0);
        e[1] = mk(0, 0, 0, 1, 4, 1);
        e[2] = mk(1, 1, 0, 0, 10, 1);
        f[0] = mk(0, 0, 0, 0, 0, 0);
        f[1] = mk(0, 0, 0, 1, 5, 1);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(s[i]);
            vectors++;
            if (observe() !== e[i]) begin
                miscompares++;
                $display("FAIL boost_up[%0d]: got %s, expected %s", i, fmt(observe()), fmt(e[i]));
            end
        end
        do_reset();
        for (int i = 0; i < 2; i++) begin
            send(t[i]);
            vectors++;
            if (observe() !== f[i]) begin
                miscompares++;
                $display("FAIL plain_step_at_up_trigger[%0d]: got %s, expected %s", i, fmt(observe()), fmt(f[i]));
            end
        end
    endtask

    task automatic test_boost_down();
        int   s [4] = '{7, -2, -20, -29};
        int   t [2] = '{-2, -11};
        obs_t e [4];
        obs_t f [2];
        e[0] = mk(0, 0, 0, 0, 0, 0);
        e[1] = mk(0, 1, 0, 0, -9, 0);
        e[2] = mk(0, 1, 0, 0, -18, 0);
        e[3] = mk(0, 1, 0, 0, -9, 0);
        f[0] = mk(0, 0, 0, 0, 0, 0);
        f[1] = mk(0, 0, 0, 1, -9, 1);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(s[i]);
            vectors++;
            if (observe() !== e[i]) begin
                miscompares++;
                $display("FAIL boost_down[%0d]: got %s, expected %s", i, fmt(observe()), fmt(e[i]));
            end
        end
        do_reset();
        for (int i = 0; i < 2; i++) begin
            send(t[i]);
            vectors++;
            if (observe() !== f[i]) begin
                miscompares++;
                $display("FAIL plain_step_at_down_trigger[%0d]: got %s, expected %s", i, fmt(observe()), fmt(f[i]));
            end
        end
    endtask

    task automatic test_hold();
        int   a [2] = '{235, 235};
        int   b [6] = '{225, 230, 235, 235, 240, 240};
        int   c [5] = '{-212, -221, -230, -230, -239};
        int   d [3] = '{300, 250, 250};
        obs_t ea [2];
        obs_t eb [6];
        obs_t ec [5];
        obs_t ed [3];
        ea[0] = mk(0, 0, 0, 0, 0, 0);
        ea[1] = mk(0, 0, 1, 0, 0, 0);
        eb[0] = mk(0, 0, 0, 0, 0, 0);
        eb[1] = mk(1, 1, 0, 0, 5, 0);
        eb[2] = mk(1, 1, 0, 0, 5, 0);
        eb[3] = mk(1, 1, 1, 0, 0, 0);
        eb[4] = mk(1, 0, 0, 1, 5, 1);
        eb[5] = mk(1, 1, 1, 0, 0, 1);
        ec[0] = mk(0, 0, 0, 0, 0, 0);
        ec[1] = mk(0, 1, 0, 0, -9, 0);
        ec[2] = mk(0, 1, 0, 0, -9, 0);
        ec[3] = mk(0, 1, 1, 0, 0, 0);
        ec[4] = mk(0, 0, 0, 1, -9, 1);
        ed[0] = mk(0, 0, 0, 0, 0, 0);
        ed[1] = mk(0, 0, 0, 1, -50, 1);
        ed[2] = mk(0, 0, 1, 0, 0, 1);

        do_reset();
        for (int i = 0; i < 2; i++) begin
            send(a[i]);
            vectors++;
            if (observe() !== ea[i]) begin
                miscompares++;
                $display("FAIL hold_primed[%0d]: got %s, expected %s", i, fmt(observe()), fmt(ea[i]));
            end
        end
        vectors++;
        if (dut.state !== PRIMED) begin
            miscompares++;
            $display("FAIL hold_primed_state: got %0d, expected %0d", dut.state, PRIMED);
        end

        do_reset();
        for (int i = 0; i < 6; i++) begin
            send(b[i]);
            vectors++;
            if (observe() !== eb[i]) begin
                miscompares++;
                $display("FAIL up_saturation[%0d]: got %s, expected %s", i, fmt(observe()), fmt(eb[i]));
            end
        end

        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(c[i]);
            vectors++;
            if (observe() !== ec[i]) begin
                miscompares++;
                $display("FAIL down_saturation[%0d]: got %s, expected %s", i, fmt(observe()), fmt(ec[i]));
            end
        end

        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(d[i]);
            vectors++;
            if (observe() !== ed[i]) begin
                miscompares++;
                $display("FAIL fault_hold_no_mode[%0d]: got %s, expected %s", i, fmt(observe()), fmt(ed[i]));
            end
        end
        vectors++;
        if (dut.state !== PRIMED) begin
            miscompares++;
            $display("FAIL fault_hold_no_mode_state: got %0d, expected %0d", dut.state, PRIMED);
        end
    endtask

    task automatic test_no_sat_hold();
        int   s [3] = '{10, 10, 15};
        obs_t e [3];
        e[0] = mk(0, 0, 0, 0, 0, 0);
        e[1] = mk(0, 0, 0, 1, 0, 1);
        e[2] = mk(1, 1, 0, 0, 5, 1);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(s[i]);
            vectors++;
            if (observe() !== e[i]) begin
                miscompares++;
                $display("FAIL no_sat_hold[%0d]: got %s, expected %s", i, fmt(observe()), fmt(e[i]));
            end
            if (i == 1) begin
                vectors++;
                if (dut.state !== FAULT) begin
                    miscompares++;
                    $display("FAIL no_sat_hold_state: got %0d, expected %0d", dut.state, FAULT);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int   s [6] = '{-50, -45, -40, -49, -58, -50};
        obs_t e [6];
        obs_t q;
        e[0] = mk(0, 0, 0, 0, 0, 0);
        e[1] = mk(1, 1, 0, 0, 5, 0);
        e[2] = mk(1, 1, 0, 0, 5, 0);
        e[3] = mk(0, 1, 0, 0, -9, 0);
        e[4] = mk(0, 1, 0, 0, -9, 0);
        e[5] = mk(0, 0, 0, 1, 8, 1);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send(s[i]);
            vectors++;
            if (observe() !== e[i]) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: got %s, expected %s", i, fmt(observe()), fmt(e[i]));
            end
        end
        // Idle cycles: err drops, everything else holds.
        q = mk(0, 0, 0, 0, 8, 1);
        for (int i = 0; i < 2; i++) begin
            idle();
            vectors++;
            if (observe() !== q) begin
                miscompares++;
                $display("FAIL idle_hold[%0d]: got %s, expected %s", i, fmt(observe()), fmt(q));
            end
        end
    endtask

    task automatic test_err_saturation();
        do_reset();
        send(0);
        for (int i = 1; i <= 300; i++) begin
            send(i);
            if (i == 254 || i == 255 || i == 300) begin
                vectors++;
                if (err_cnt !== ERR_W'(i > 255 ? 255 : i) || err !== 1'b1) begin
                    miscompares++;
                    $display("FAIL err_cnt_sat_at_%0d: got err_cnt=%0d err=%0d, expected err_cnt=%0d err=1",
                             i, err_cnt, err, (i > 255 ? 255 : i));
                end
            end
        end
        idle();
        send(400);
        vectors++;
        if (err_cnt !== 8'd255) begin
            miscompares++;
            $display("FAIL err_cnt_sat_hold: got %0d, expected 255", err_cnt);
        end
    endtask

    task automatic test_async_reset();
        obs_t z;
        obs_t e;
        z = mk(0, 0, 0, 0, 0, 0);
        do_reset();
        send(-50);
        send(-45);
        send(-10);
        // Assert reset away from any clock edge and look before the next one.
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (observe() !== z) begin
            miscompares++;
            $display("FAIL async_reset_outputs: got %s, expected %s", fmt(observe()), fmt(z));
        end
        @(negedge clk);
        rst = 1'b0;
        send(10);
        vectors++;
        if (observe() !== z) begin
            miscompares++;
            $display("FAIL after_reset_first: got %s, expected %s", fmt(observe()), fmt(z));
        end
        send(15);
        e = mk(1, 1, 0, 0, 5, 0);
        vectors++;
        if (observe() !== e) begin
            miscompares++;
            $display("FAIL after_reset_second: got %s, expected %s", fmt(observe()), fmt(e));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_up_basic();
        test_boost_up();
        test_boost_down();
        test_hold();
        test_no_sat_hold();
        test_back_to_back();
        test_err_saturation();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
